// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency RAM port between LEGv8 IF and MEM stages.
//            Optional macro ARB_ROUND_ROBIN_EN alternates grants on a tie.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              grant_mem,
    output logic              busy
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_access   = 2'd1;
    localparam logic [1:0] c_resp     = 2'd2;
    localparam logic [3:0] c_cnt_init = 4'(WAIT_STATES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_grant_mem;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    logic w_mem_req;
    logic w_any_req;
    logic w_pick_mem;

    assign w_mem_req = mem_rd | mem_wr;
    assign w_any_req = w_mem_req | if_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port that lost the previous grant wins.
    assign w_pick_mem = w_mem_req & (~if_req | ~r_grant_mem);
`else
    assign w_pick_mem = w_mem_req;
`endif

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:   if (w_any_req) w_state_nxt = c_access;
            c_access: if (r_cnt == 4'd0) w_state_nxt = c_resp;
            c_resp:   w_state_nxt = c_idle;
            default:  w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_cnt       <= 4'd0;
            r_grant_mem <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_any_req) begin
                        r_grant_mem <= w_pick_mem;
                        // A simultaneous read and write is treated as a write.
                        r_we        <= w_pick_mem & mem_wr;
                        r_addr      <= w_pick_mem ? mem_addr : if_addr;
                        r_wdata     <= w_pick_mem ? mem_wdata : r_wdata;
                        r_cnt       <= c_cnt_init;
                    end
                end
                c_access: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            if (r_grant_mem) r_mem_rdata <= ram_rdata;
                            else             r_if_rdata  <= ram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_en    = (r_state == c_access);
    assign ram_we    = (r_state == c_access) & r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign grant_mem = r_grant_mem;
    assign busy      = (r_state != c_idle);

    assign if_stall  = if_req    & ~((r_state == c_resp) & ~r_grant_mem);
    assign mem_stall = w_mem_req & ~((r_state == c_resp) &  r_grant_mem);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (WAIT_STATES=2).
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [63:0] if_rdata;
    logic        if_stall;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_stall;
    logic        ram_en;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;
    logic        grant_mem;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_STATES(2)) dut (
        .clk(clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .grant_mem(grant_mem), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int grants[$];
        int if_drops;
        logic prev_en;
        int budget;

        Reset = 1'b0; if_req = 1'b1; if_addr = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;

        // Reset held two cycles with an IF request pending
        cyc(); cyc();
        @(negedge clk);
        check("rst_ram_en", ram_en, 0);
        check("rst_busy", busy, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_if_stall", if_stall, 1);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_ram_addr", ram_addr, 0);
        cyc();
        Reset = 1'b1; if_req = 1'b0;

        // IF read: cycle 0
        cyc();
        if_req = 1'b1; if_addr = 64'h10; ram_rdata = 64'h8B020020;
        @(negedge clk); check("if_c0_stall", if_stall, 1);
        cyc(); @(negedge clk);
        check("if_c1_stall", if_stall, 1);
        check("if_c1_en", ram_en, 1);
        check("if_c1_addr", ram_addr, 64'h10);
        check("if_c1_we", ram_we, 0);
        check("if_c1_grant", grant_mem, 0);
        cyc(); @(negedge clk);
        check("if_c2_stall", if_stall, 1);
        check("if_c2_addr", ram_addr, 64'h10);
        cyc(); @(negedge clk);
        check("if_c3_stall", if_stall, 0);
        check("if_c3_rdata", if_rdata, 64'h8B020020);
        check("if_c3_en", ram_en, 0);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        check("if_c4_busy", busy, 0);

        // Both request together: MEM first, then IF
        cyc();
        if_req = 1'b1; if_addr = 64'h18; mem_rd = 1'b1; mem_addr = 64'h40; ram_rdata = 64'h1111;
        cyc(); @(negedge clk);
        check("arb_c1_grant", grant_mem, 1);
        check("arb_c1_addr", ram_addr, 64'h40);
        check("arb_c1_ifst", if_stall, 1);
        cyc(); cyc(); @(negedge clk);
        check("arb_c3_memst", mem_stall, 0);
        check("arb_c3_ifst", if_stall, 1);
        check("arb_c3_mrdata", mem_rdata, 64'h1111);
        cyc();
        mem_rd = 1'b0; ram_rdata = 64'h2222;
        cyc(); @(negedge clk);
        check("arb_c5_grant", grant_mem, 0);
        check("arb_c5_addr", ram_addr, 64'h18);
        cyc(); @(negedge clk);
        check("arb_c6_ifst", if_stall, 1);
        cyc(); @(negedge clk);
        check("arb_c7_ifst", if_stall, 0);
        check("arb_c7_ifrdata", if_rdata, 64'h2222);
        check("arb_c7_mrdata", mem_rdata, 64'h1111);
        cyc();
        if_req = 1'b0;

        // MEM write
        cyc();
        mem_wr = 1'b1; mem_addr = 64'h20; mem_wdata = 64'hDEAD; ram_rdata = 64'h5555;
        cyc(); @(negedge clk);
        check("wr_c1_we", ram_we, 1);
        check("wr_c1_wdata", ram_wdata, 64'hDEAD);
        check("wr_c1_addr", ram_addr, 64'h20);
        cyc(); @(negedge clk);
        check("wr_c2_we", ram_we, 1);
        cyc(); @(negedge clk);
        check("wr_c3_memst", mem_stall, 0);
        check("wr_c3_we", ram_we, 0);
        check("wr_c3_mrdata", mem_rdata, 64'h1111);
        cyc();
        mem_wr = 1'b0;

        // Read and write together behave as a write
        cyc();
        mem_rd = 1'b1; mem_wr = 1'b1; mem_wdata = 64'hBEEF; ram_rdata = 64'h6666;
        cyc(); @(negedge clk);
        check("rw_c1_we", ram_we, 1);
        check("rw_c1_wdata", ram_wdata, 64'hBEEF);
        cyc(); cyc(); @(negedge clk);
        check("rw_c3_memst", mem_stall, 0);
        check("rw_c3_mrdata", mem_rdata, 64'h1111);
        cyc();
        mem_rd = 1'b0; mem_wr = 1'b0;

        // Continuous contention for 24 cycles, starting from a fresh reset
        cyc(); Reset = 1'b0;
        cyc(); cyc();
        Reset = 1'b1; if_req = 1'b1; mem_rd = 1'b1; ram_rdata = 64'h9999;
        prev_en = 1'b0; if_drops = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (ram_en && !prev_en) grants.push_back(int'(grant_mem));
            if (!if_stall) if_drops++;
            prev_en = ram_en;
            cyc();
        end
        if_req = 1'b0; mem_rd = 1'b0;
        check("cont_ngrants", grants.size(), 6);
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            check($sformatf("cont_grant%0d", i), (i < grants.size()) ? grants[i] : -1, (i % 2 == 0) ? 1 : 0);
`else
            check($sformatf("cont_grant%0d", i), (i < grants.size()) ? grants[i] : -1, 1);
`endif
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("cont_if_drops", if_drops, 3);
`else
        check("cont_if_drops", if_drops, 0);
`endif
        budget = 10;
        @(negedge clk);
        while (busy && budget > 0) begin
            cyc(); @(negedge clk);
            budget--;
        end
        check("drain_busy", busy, 0);

        // Reset during the second ACCESS cycle of a MEM read
        cyc();
        mem_rd = 1'b1; mem_addr = 64'h30; ram_rdata = 64'h7777;
        @(negedge clk);
        check("rr_c0_mrdata", mem_rdata, 64'h9999);
        cyc(); @(negedge clk);
        check("rr_c1_en", ram_en, 1);
        cyc();
        Reset = 1'b0;
        @(negedge clk);
        check("rr_c2_en", ram_en, 1);
        cyc(); @(negedge clk);
        check("rr_c3_busy", busy, 0);
        check("rr_c3_en", ram_en, 0);
        check("rr_c3_mrdata", mem_rdata, 0);
        check("rr_c3_memst", mem_stall, 1);
        cyc();
        Reset = 1'b1;
        @(negedge clk);
        cyc(); @(negedge clk);
        check("rr_c5_en", ram_en, 1);
        check("rr_c5_grant", grant_mem, 1);
        check("rr_c5_addr", ram_addr, 64'h30);
        cyc(); cyc(); @(negedge clk);
        check("rr_c7_memst", mem_stall, 0);
        check("rr_c7_mrdata", mem_rdata, 64'h7777);
        cyc();
        mem_rd = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
